vit_frame_ctrl: RTL
===================

# vit_frame_ctrl

Frame sequencer for the Viterbi decoder. It accepts received symbol pairs over a valid/ready stream, registers each one into the branch-metric bank, and enables ACS and survivor-memory writes for that symbol. It then injects the zero-tail flush symbols, launches traceback, and reports frame completion. It sits between the channel input and the BMC/ACS/survivor-memory/traceback datapath, and is the only block that drives their enables.

## Interface
- FRAME_LEN, 64: data symbols per frame (≥2)
- TAIL_LEN, 2: flush symbols appended per frame (encoder K−1)
- TB_TIMEOUT, 1024: traceback watchdog limit in cycles (used only with macro)
- Derived localparam ADDR_W = $clog2(FRAME_LEN+TAIL_LEN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame launch request
- in_valid  in  1  input symbol valid
- in_ready  out  1  controller accepts symbol this cycle
- in_rx_pair  in  2  received symbol pair
- bmc_rx_pair  out  2  registered symbol presented to BMC bank
- acs_en  out  1  ACS/path-metric update enable for bmc_rx_pair
- mem_wr_en  out  1  survivor memory write enable
- mem_wr_addr  out  ADDR_W  survivor memory write address (trellis step)
- tb_start  out  1  one-cycle traceback launch
- tb_addr  out  ADDR_W  traceback start address, valid while tb_start=1
- tb_done  in  1  traceback finished pulse
- busy  out  1  high in any state but IDLE
- frame_done  out  1  one-cycle completion pulse
- tb_err  out  1  one-cycle watchdog abort pulse (0 without macro)

## Operation
- States: IDLE, FILL, FLUSH, TRACE. An internal step counter `step` spans 0..FRAME_LEN+TAIL_LEN−1.
- IDLE: in_ready=0. start=1 → FILL, step←0. start outside IDLE is ignored.
- FILL: in_ready=1. Each beat with in_valid&in_ready does the following on the next cycle: bmc_rx_pair←in_rx_pair, acs_en=1, mem_wr_en=1, mem_wr_addr=step; then step increments. in_valid=0 produces a bubble: acs_en=0, mem_wr_en=0, step held. The beat with step==FRAME_LEN−1 → FLUSH. in_ready drops in the same cycle the state leaves FILL.
- FLUSH: in_ready=0. Drives TAIL_LEN consecutive steps with bmc_rx_pair=2'b00, acs_en=1, mem_wr_en=1, mem_wr_addr=step, and no bubbles. After the last tail step → TRACE.
- TRACE: tb_start pulses in the first TRACE cycle with tb_addr=FRAME_LEN+TAIL_LEN−1. Then waits for tb_done.
  - tb_done → frame_done pulse next cycle, return to IDLE.
  - tb_done in any other state is ignored.
- Outputs not listed for a state are 0. bmc_rx_pair holds its last value while acs_en=0.
- Reset at any point, including mid-frame: state IDLE, step 0, all outputs 0, bmc_rx_pair 2'b00. The frame in progress is discarded.

## Timing
- Input beat → acs_en/mem_wr_en: 1 cycle latency.
- Back-to-back beats give one ACS step per cycle.
- Minimum frame: 1 (start) + FRAME_LEN + TAIL_LEN + 1 (tb_start) + traceback latency + 1 (frame_done) cycles.
- Last FILL beat accepted at cycle t: first flush step output at t+2. There is no gap between the final data step and the first tail step.
- frame_done and start in the same cycle: frame_done is reported and the FSM returns to IDLE. That start is not honored; a new start is required next cycle or later.
- mem_wr_addr never exceeds FRAME_LEN+TAIL_LEN−1 and does not wrap within a frame.

## Configuration
- VIT_FRAME_CTRL_TB_TIMEOUT_EN defined:
  - A watchdog counts TRACE cycles after tb_start.
  - If TB_TIMEOUT cycles elapse without tb_done: pulse tb_err, go to IDLE, no frame_done.
  - tb_done arriving in the same cycle as the timeout wins: frame_done, no tb_err.
- Macro undefined: no watchdog logic, tb_err tied 0, TRACE waits indefinitely.

## Structure
- Shared package vit_pkg holds:
  - state enum typedef (IDLE/FILL/FLUSH/TRACE)
  - symbol-pair typedef (logic [1:0])
  - default TAIL_LEN constant
- Sub-module vit_tb_watchdog (counter + compare) is instantiated only under VIT_FRAME_CTRL_TB_TIMEOUT_EN.
- FSM, step counter and the symbol register live in the top module.

## Test plan
- FRAME_LEN=4, TAIL_LEN=2, start then 4 back-to-back beats 2'b11,01,10,00 → acs_en high 6 consecutive cycles; bmc_rx_pair 11,01,10,00,00,00; mem_wr_addr 0..5; tb_start with tb_addr=5.
- Same frame with in_valid low on beat 2 for 3 cycles → 3 bubble cycles with acs_en=0; addresses still 0..5 contiguous; in_ready stays 1 through the gap.
- tb_done asserted 7 cycles after tb_start → frame_done pulses exactly once, the next cycle; busy=0 the following cycle; in_ready=0 throughout TRACE.
- rst asserted after 2 accepted beats → all outputs 0 next cycle; a fresh start yields mem_wr_addr restarting at 0.
- start asserted during FILL and during TRACE → no effect on step or state; in_valid in IDLE → in_ready=0, nothing accepted.
- With macro defined, TB_TIMEOUT=16 and tb_done withheld → tb_err pulses 16 cycles after tb_start, state returns to IDLE, no frame_done. Without the macro → no tb_err, busy stays high.

Source files
------------

// File: rtl/vit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vit_pkg
// Description : Shared types and constants for the Viterbi decoder frame
//               sequencer (FSM states, symbol-pair type, default tail length).
// Revision    : 1.0 - initial release
// ============================================================================
package vit_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_TRACE = 2'd3
    } vit_state_t;

    // One received symbol pair as presented to the branch-metric bank
    typedef logic [1:0] sym_pair_t;

    // Zero-tail length for a K=3 encoder (K-1 flush symbols)
    localparam int c_default_tail_len = 2;

endpackage : vit_pkg
`default_nettype wire

// File: rtl/vit_tb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : vit_tb_watchdog
// Description : Traceback watchdog. Counts cycles while enabled and flags
//               expiry in the TB_TIMEOUT-th enabled cycle. The count clears
//               whenever the enable drops, so each traceback starts fresh.
// Revision    : 1.0 - initial release
// ============================================================================
module vit_tb_watchdog #(
    parameter  int TB_TIMEOUT = 1024,
    localparam int CNT_W      = $clog2(TB_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TB_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter: saturates at the limit, clears when not tracing
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = en && (r_cnt == c_cnt_last);

endmodule : vit_tb_watchdog
`default_nettype wire

// File: rtl/vit_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vit_frame_ctrl
// Description : Viterbi frame sequencer. Accepts symbol pairs, drives the
//               BMC/ACS/survivor-memory enables, appends the zero tail,
//               launches traceback and reports frame completion.
//               Optional traceback watchdog: VIT_FRAME_CTRL_TB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vit_frame_ctrl
    import vit_pkg::*;
#(
    parameter  int FRAME_LEN  = 64,
    parameter  int TAIL_LEN   = c_default_tail_len,
    parameter  int TB_TIMEOUT = 1024,
    localparam int ADDR_W     = $clog2(FRAME_LEN + TAIL_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_rx_pair,
    output logic [1:0]        bmc_rx_pair,
    output logic              acs_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              tb_start,
    output logic [ADDR_W-1:0] tb_addr,
    input  logic              tb_done,
    output logic              busy,
    output logic              frame_done,
    output logic              tb_err
);

    localparam logic [ADDR_W-1:0] c_fill_last = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] c_step_last = ADDR_W'(FRAME_LEN + TAIL_LEN - 1);

    vit_state_t        r_state;
    logic [ADDR_W-1:0] r_step;
    logic              r_in_ready;
    sym_pair_t         r_bmc_rx_pair;
    logic              r_acs_en;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_wr_addr;
    logic              r_tb_start;
    logic [ADDR_W-1:0] r_tb_addr;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_tb_err;
    logic              w_wd_expired;

`ifdef VIT_FRAME_CTRL_TB_TIMEOUT_EN
    vit_tb_watchdog #(
        .TB_TIMEOUT (TB_TIMEOUT)
    ) u_tb_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (r_state == ST_TRACE),
        .expired (w_wd_expired)
    );
`else
    assign w_wd_expired = 1'b0;
`endif

    // Frame FSM, step counter, symbol register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_step        <= '0;
            r_in_ready    <= 1'b0;
            r_bmc_rx_pair <= 2'b00;
            r_acs_en      <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_tb_start    <= 1'b0;
            r_tb_addr     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_tb_err      <= 1'b0;
        end else begin
            // Pulse-type outputs default low; bmc_rx_pair holds
            r_acs_en      <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_tb_start    <= 1'b0;
            r_tb_addr     <= '0;
            r_frame_done  <= 1'b0;
            r_tb_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start coinciding with the frame_done pulse is dropped
                    if (start && !r_frame_done) begin
                        r_state    <= ST_FILL;
                        r_step     <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    // in_ready is high throughout FILL, so in_valid alone is a beat
                    if (in_valid) begin
                        r_bmc_rx_pair <= in_rx_pair;
                        r_acs_en      <= 1'b1;
                        r_mem_wr_en   <= 1'b1;
                        r_mem_wr_addr <= r_step;
                        r_step        <= r_step + 1'b1;
                        if (r_step == c_fill_last) begin
                            r_state    <= ST_FLUSH;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_bmc_rx_pair <= 2'b00;
                    r_acs_en      <= 1'b1;
                    r_mem_wr_en   <= 1'b1;
                    r_mem_wr_addr <= r_step;
                    r_step        <= r_step + 1'b1;
                    if (r_step == c_step_last) begin
                        r_state    <= ST_TRACE;
                        r_step     <= '0;
                        r_tb_start <= 1'b1;
                        r_tb_addr  <= c_step_last;
                    end
                end
                ST_TRACE: begin
                    // tb_done takes priority over a coincident watchdog expiry
                    if (tb_done) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else if (w_wd_expired) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_tb_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign bmc_rx_pair = r_bmc_rx_pair;
    assign acs_en      = r_acs_en;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_addr = r_mem_wr_addr;
    assign tb_start    = r_tb_start;
    assign tb_addr     = r_tb_addr;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign tb_err      = r_tb_err;

endmodule : vit_frame_ctrl
`default_nettype wire
